hedios_packet_rx: RTL and testbench
===================================

HEDIOS_PACKET_RX -- requirements
Module: hedios_packet_rx

Interface
REQ-001 Parameter CMD_BYTES, default 1: command field width in bytes (1..4).
REQ-002 Parameter DATA_BYTES, default 4: data field width in bytes (1..8).
REQ-003 Parameter FIFO_DEPTH, default 16: packet queue depth; power of two, 2..256.
REQ-004 Parameter TIMEOUT_CYCLES, default 2000: max clk cycles between bytes inside a frame.
REQ-005 Parameter SYNC_BYTE, default 8'hA5: frame start marker.
REQ-006 Parameter CHECK_EN, default 1: 1 = frame carries a trailing XOR checksum byte; 0 = no checksum byte.
REQ-007 clk  input  1  system clock; all logic on rising edge.
REQ-008 rst  input  1  reset, asynchronous, active-high.
REQ-009 in_valid  input  1  one-cycle strobe; in_byte holds a received serial byte.
REQ-010 in_byte  input  8  received byte.
REQ-011 out_valid  output  1  queue head holds a packet.
REQ-012 out_ready  input  1  consumer accepts the head when out_valid is high.
REQ-013 out_cmd  output  8*CMD_BYTES  head packet command.
REQ-014 out_data  output  8*DATA_BYTES  head packet data.
REQ-015 fifo_count  output  clog2(FIFO_DEPTH+1)  packets queued.
REQ-016 fifo_full  output  1  fifo_count == FIFO_DEPTH.
REQ-017 err_overflow / err_checksum / err_timeout  output  1 each  single-cycle error pulses.
REQ-018 drop_count  output  16  frames discarded since reset; saturates at 16'hFFFF.

Function
REQ-019 Frame = SYNC_BYTE, then CMD_BYTES command bytes, then DATA_BYTES data bytes, then one checksum byte if CHECK_EN=1; multi-byte fields are least-significant byte first.
REQ-020 Checksum byte = XOR of all command and data bytes; SYNC_BYTE is excluded.
REQ-021 States: HUNT, PAYLOAD, CHECK, COMMIT; reset state HUNT.
REQ-022 HUNT: an in_valid byte equal to SYNC_BYTE -> PAYLOAD with byte counter 0; any other byte is discarded silently, without an error or a count.
REQ-023 PAYLOAD: each in_valid byte is shifted into the assembly register; after byte CMD_BYTES+DATA_BYTES -> CHECK if CHECK_EN=1, else -> COMMIT.
REQ-024 CHECK: the next in_valid byte is compared with the running XOR -> COMMIT, with the match result latched.
REQ-025 COMMIT lasts exactly one cycle, then -> HUNT; checksum mismatch -> err_checksum pulse, no write.
REQ-026 In COMMIT, a good frame writes the queue unless the queue is full with no simultaneous pop; in that case -> err_overflow pulse and the frame is dropped.
REQ-027 An in_valid byte arriving during COMMIT is evaluated under the HUNT rule.
REQ-028 In PAYLOAD and CHECK, the idle counter clears on every in_valid and increments otherwise.
REQ-029 When the idle counter reaches TIMEOUT_CYCLES: err_timeout pulse, partial frame discarded, -> HUNT; HUNT has no timeout.
REQ-030 Each err_* pulse increments drop_count by 1; at most one err_* pulse fires per cycle.
REQ-031 Latency: final frame byte accepted in cycle N -> COMMIT in N+1 -> out_valid high in N+2 when the queue was empty.
REQ-032 Queue is show-ahead: out_valid = (fifo_count != 0), and out_cmd/out_data always present the head entry.
REQ-033 Pop occurs when out_valid && out_ready; out_ready with an empty queue has no effect.
REQ-034 Simultaneous push and pop leaves fifo_count unchanged, including when the queue is full.
REQ-035 Pointers wrap modulo FIFO_DEPTH; ordering is strictly FIFO.

Reset
REQ-036 On rst: state HUNT, counters 0, queue empty, out_valid=0, fifo_full=0, fifo_count=0, all err_* = 0, drop_count=0.
REQ-037 rst asserted mid-frame discards the partial frame and all queued packets, with no error pulse.
REQ-038 out_cmd/out_data are don't-care while out_valid=0.

Structure
REQ-039 Shared package hedios_pkg holds the state encoding, the default SYNC_BYTE, and the error-code constants.
REQ-040 The queue is a sub-module hedios_pkt_fifo, parameterised by width (8*(CMD_BYTES+DATA_BYTES)) and FIFO_DEPTH.
REQ-041 Byte deserialisation lives outside this block; the existing serial receiver drives in_valid/in_byte.

Verification
REQ-042 Defaults: bytes A5,10,44,33,22,11,checksum 0x10^0x44^0x33^0x22^0x11 -> out_cmd=0x10, out_data=0x11223344, out_valid two cycles after the checksum strobe.
REQ-043 Same frame with checksum byte 0x00 -> err_checksum one-cycle pulse, drop_count=1, out_valid stays 0.
REQ-044 Send A5,10 then no in_valid for 2000 cycles -> err_timeout pulse, state HUNT; a following valid frame is received correctly.
REQ-045 17 valid frames, out_ready=0 -> fifo_full after frame 16, err_overflow on frame 17, drop_count=1; draining returns frames 1..16 in order.
REQ-046 Queue full, out_ready=1 in the COMMIT cycle of a new frame -> no overflow, fifo_count stays 16.
REQ-047 rst pulse after A5,10,44 with 3 packets queued -> fifo_count=0, out_valid=0, no error pulse; next frame decodes normally.

Source files
------------

// File: rtl/hedios_pkg.sv
// Shared definitions for the HEDIOS packet receiver: FSM states, default
// frame marker and error codes.
package hedios_pkg;

    typedef enum logic [1:0] {
        HUNT,
        PAYLOAD,
        CHECK,
        COMMIT
    } rx_state_e;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

    typedef enum logic [1:0] {
        ERR_NONE,
        ERR_OVERFLOW,
        ERR_CHECKSUM,
        ERR_TIMEOUT
    } err_code_e;

endpackage

// File: rtl/hedios_pkt_fifo.sv
// Show-ahead packet queue; push and pop may occur together even when full.
module hedios_pkt_fifo #(
    parameter int unsigned WIDTH = 40,
    parameter int unsigned DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push_i,
    input  logic [WIDTH-1:0]             wdata_i,
    input  logic                         pop_i,
    output logic [WIDTH-1:0]             rdata_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         empty_o,
    output logic                         full_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset; validity is tracked by count_q.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/hedios_packet_rx.sv
// Frame parser for the HEDIOS byte stream: finds SYNC, assembles command/data
// fields, verifies the XOR checksum and queues good packets.
module hedios_packet_rx
    import hedios_pkg::*;
#(
    parameter int unsigned CMD_BYTES      = 1,
    parameter int unsigned DATA_BYTES     = 4,
    parameter int unsigned FIFO_DEPTH     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 2000,
    parameter logic [7:0]  SYNC_BYTE      = DEFAULT_SYNC_BYTE,
    parameter bit          CHECK_EN       = 1'b1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    input  logic [7:0]                        in_byte,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [8*CMD_BYTES-1:0]            out_cmd,
    output logic [8*DATA_BYTES-1:0]           out_data,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
    output logic                              fifo_full,
    output logic                              err_overflow,
    output logic                              err_checksum,
    output logic                              err_timeout,
    output logic [15:0]                       drop_count
);

    localparam int unsigned TOTAL = CMD_BYTES + DATA_BYTES;
    localparam int unsigned W     = 8 * TOTAL;
    localparam int unsigned IW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [3:0]    LAST_IDX   = 4'(TOTAL - 1);
    localparam logic [IW-1:0] IDLE_LIMIT = IW'(TIMEOUT_CYCLES - 1);

    rx_state_e     state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [IW-1:0] idle_q, idle_d;
    logic [W-1:0]  asm_q, asm_d;
    logic [7:0]    xor_q, xor_d;
    logic          match_q, match_d;
    err_code_e     err_q, err_d;
    logic [15:0]   drop_q;

    logic          sync_hit;
    logic          idle_expired;
    logic          push;
    logic          pop;
    logic          fifo_empty;
    logic [W-1:0]  head;

    assign sync_hit     = in_valid && (in_byte == SYNC_BYTE);
    assign idle_expired = !in_valid && (idle_q == IDLE_LIMIT);
    assign pop          = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= HUNT;
            cnt_q   <= '0;
            idle_q  <= '0;
            asm_q   <= '0;
            xor_q   <= '0;
            match_q <= 1'b0;
            err_q   <= ERR_NONE;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idle_q  <= idle_d;
            asm_q   <= asm_d;
            xor_q   <= xor_d;
            match_q <= match_d;
            err_q   <= err_d;
            if (err_d != ERR_NONE && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idle_d  = idle_q;
        asm_d   = asm_q;
        xor_d   = xor_q;
        match_d = match_q;
        err_d   = ERR_NONE;
        push    = 1'b0;
        unique case (state_q)
            HUNT: begin
                if (sync_hit) begin
                    state_d = PAYLOAD;
                    cnt_d   = '0;
                    idle_d  = '0;
                    xor_d   = '0;
                end
            end
            PAYLOAD: begin
                if (in_valid) begin
                    asm_d   = {in_byte, asm_q[W-1:8]};
                    xor_d   = xor_q ^ in_byte;
                    idle_d  = '0;
                    cnt_d   = cnt_q + 4'd1;
                    match_d = 1'b1;
                    if (cnt_q == LAST_IDX) state_d = CHECK_EN ? CHECK : COMMIT;
                end else if (idle_expired) begin
                    err_d   = ERR_TIMEOUT;
                    state_d = HUNT;
                end else begin
                    idle_d = idle_q + 1'b1;
                end
            end
            CHECK: begin
                if (in_valid) begin
                    match_d = (in_byte == xor_q);
                    idle_d  = '0;
                    state_d = COMMIT;
                end else if (idle_expired) begin
                    err_d   = ERR_TIMEOUT;
                    state_d = HUNT;
                end else begin
                    idle_d = idle_q + 1'b1;
                end
            end
            COMMIT: begin
                if (!match_q)                err_d = ERR_CHECKSUM;
                else if (fifo_full && !pop)  err_d = ERR_OVERFLOW;
                else                         push  = 1'b1;
                // A byte landing in this cycle is judged as if already in HUNT.
                state_d = HUNT;
                if (sync_hit) begin
                    state_d = PAYLOAD;
                    cnt_d   = '0;
                    idle_d  = '0;
                    xor_d   = '0;
                end
            end
            default: state_d = HUNT;
        endcase
    end

    hedios_pkt_fifo #(
        .WIDTH (W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .wdata_i (asm_q),
        .pop_i   (pop),
        .rdata_o (head),
        .count_o (fifo_count),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    assign out_valid    = !fifo_empty;
    assign out_cmd      = head[8*CMD_BYTES-1:0];
    assign out_data     = head[W-1:8*CMD_BYTES];
    assign err_overflow = (err_q == ERR_OVERFLOW);
    assign err_checksum = (err_q == ERR_CHECKSUM);
    assign err_timeout  = (err_q == ERR_TIMEOUT);
    assign drop_count   = drop_q;

endmodule

// File: tb/tb_hedios_packet_rx.sv
// Bench for hedios_packet_rx: table vectors, corner-case sequences and a
// randomized frame stream checked against a packet-queue model.
module tb_hedios_packet_rx;

    localparam logic [7:0] SYNC = 8'hA5;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_byte;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_cmd;
    logic [31:0] out_data;
    logic [4:0]  fifo_count;
    logic        fifo_full;
    logic        err_overflow;
    logic        err_checksum;
    logic        err_timeout;
    logic [15:0] drop_count;

    always #5 clk = ~clk;

    hedios_packet_rx #(
        .CMD_BYTES      (1),
        .DATA_BYTES     (4),
        .FIFO_DEPTH     (16),
        .TIMEOUT_CYCLES (2000),
        .SYNC_BYTE      (8'hA5),
        .CHECK_EN       (1'b1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_byte      (in_byte),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_cmd      (out_cmd),
        .out_data     (out_data),
        .fifo_count   (fifo_count),
        .fifo_full    (fifo_full),
        .err_overflow (err_overflow),
        .err_checksum (err_checksum),
        .err_timeout  (err_timeout),
        .drop_count   (drop_count)
    );

    typedef struct packed {
        logic [7:0]  cmd;
        logic [31:0] data;
        logic [7:0]  chk;
        logic        exp_valid;
        logic        exp_err;
    } vec_t;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned n_ovf    = 0;
    int unsigned n_chk    = 0;
    int unsigned n_to     = 0;
    bit          rand_ready = 1'b0;
    logic [39:0] exp_q [$];

    always @(negedge clk) begin
        if (err_overflow) n_ovf++;
        if (err_checksum) n_chk++;
        if (err_timeout)  n_to++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [7:0] chk_of(input logic [7:0] cmd, input logic [31:0] data);
        return cmd ^ data[7:0] ^ data[15:8] ^ data[23:16] ^ data[31:24];
    endfunction

    // Any pop at the coming edge must deliver the oldest expected packet.
    task automatic tick();
        logic [39:0] e;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("pop_with_empty_model", 64'(out_valid), 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("pop_cmd", 64'(out_cmd), 64'(e[39:32]));
                check("pop_data", 64'(out_data), 64'(e[31:0]));
            end
        end
        @(posedge clk);
        #1;
        if (rand_ready) out_ready = ($urandom_range(0, 2) != 0);
    endtask

    task automatic send_byte(input logic [7:0] b);
        in_valid = 1'b1;
        in_byte  = b;
        tick();
        in_valid = 1'b0;
        in_byte  = 8'h00;
    endtask

    task automatic gap(input int unsigned max_gap);
        repeat ($urandom_range(0, max_gap)) tick();
    endtask

    task automatic send_frame(input logic [7:0] cmd, input logic [31:0] data,
                              input logic [7:0] chk, input int unsigned max_gap);
        send_byte(SYNC);
        gap(max_gap);
        send_byte(cmd);
        for (int i = 0; i < 4; i++) begin
            gap(max_gap);
            send_byte(data[8*i +: 8]);
        end
        gap(max_gap);
        send_byte(chk);
    endtask

    initial begin
        vec_t        vecs [6];
        int unsigned exp_drop;
        int unsigned at;
        bit          seen;
        int unsigned errs_before;
        int unsigned chk_before;
        int unsigned ovf_before;
        int unsigned to_before;
        int unsigned n_bad;
        logic [7:0]  cmd;
        logic [31:0] data;
        logic [7:0]  chk;
        logic [7:0]  junk;

        vecs[0] = '{cmd: 8'h10, data: 32'h11223344, chk: 8'h54, exp_valid: 1'b1, exp_err: 1'b0};
        vecs[1] = '{cmd: 8'h10, data: 32'h11223344, chk: 8'h00, exp_valid: 1'b0, exp_err: 1'b1};
        vecs[2] = '{cmd: 8'hFF, data: 32'h00000000, chk: 8'hFF, exp_valid: 1'b1, exp_err: 1'b0};
        vecs[3] = '{cmd: 8'h00, data: 32'hA5A5A5A5, chk: 8'h00, exp_valid: 1'b1, exp_err: 1'b0};
        vecs[4] = '{cmd: 8'h5A, data: 32'h01020304, chk: 8'h5E, exp_valid: 1'b1, exp_err: 1'b0};
        vecs[5] = '{cmd: 8'h5A, data: 32'h01020304, chk: 8'h5F, exp_valid: 1'b0, exp_err: 1'b1};

        rst = 1'b1; in_valid = 1'b0; in_byte = 8'h00; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_fifo_count", 64'(fifo_count), 64'd0);
        check("rst_fifo_full", 64'(fifo_full), 64'd0);
        check("rst_errs", 64'({err_overflow, err_checksum, err_timeout}), 64'd0);
        check("rst_drop_count", 64'(drop_count), 64'd0);

        // Non-sync bytes in HUNT vanish without errors.
        send_byte(8'h00); send_byte(8'h10); send_byte(8'h5A);
        tick(); tick();
        check("hunt_fifo_count", 64'(fifo_count), 64'd0);
        check("hunt_drop_count", 64'(drop_count), 64'd0);
        check("hunt_err_pulses", 64'(n_ovf + n_chk + n_to), 64'd0);

        exp_drop = 0;
        for (int i = 0; i < 6; i++) begin
            send_frame(vecs[i].cmd, vecs[i].data, vecs[i].chk, 0);
            check("vec_valid_at_commit", 64'(out_valid), 64'd0);
            tick();
            if (vecs[i].exp_err) exp_drop++;
            check("vec_out_valid", 64'(out_valid), 64'(vecs[i].exp_valid));
            check("vec_err_checksum", 64'(err_checksum), 64'(vecs[i].exp_err));
            check("vec_drop_count", 64'(drop_count), 64'(exp_drop));
            if (vecs[i].exp_valid) begin
                check("vec_out_cmd", 64'(out_cmd), 64'(vecs[i].cmd));
                check("vec_out_data", 64'(out_data), 64'(vecs[i].data));
                exp_q.push_back({vecs[i].cmd, vecs[i].data});
            end
            tick();
            check("vec_err_pulse_width", 64'(err_checksum), 64'd0);
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            check("vec_count_after_pop", 64'(fifo_count), 64'd0);
        end

        // Inter-byte timeout.
        send_byte(SYNC);
        send_byte(8'h10);
        seen = 1'b0;
        at   = 0;
        for (int i = 1; i <= 2100 && !seen; i++) begin
            tick();
            if (err_timeout) begin
                seen = 1'b1;
                at   = i;
            end
        end
        exp_drop++;
        check("timeout_cycle", 64'(at), 64'd2000);
        check("timeout_drop_count", 64'(drop_count), 64'(exp_drop));
        tick();
        check("timeout_pulse_width", 64'(err_timeout), 64'd0);
        send_frame(8'h10, 32'h11223344, 8'h54, 0);
        tick();
        check("post_timeout_valid", 64'(out_valid), 64'd1);
        check("post_timeout_cmd", 64'(out_cmd), 64'h10);
        check("post_timeout_data", 64'(out_data), 64'h11223344);
        exp_q.push_back({8'h10, 32'h11223344});
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Fill the queue, overflow it, then push and pop on a full queue.
        for (int f = 1; f <= 17; f++) begin
            cmd  = 8'(f);
            data = $urandom;
            send_frame(cmd, data, chk_of(cmd, data), 0);
            tick();
            if (f <= 16) exp_q.push_back({cmd, data});
            if (f == 15) check("fill15_full", 64'(fifo_full), 64'd0);
            if (f == 16) begin
                check("fill16_full", 64'(fifo_full), 64'd1);
                check("fill16_count", 64'(fifo_count), 64'd16);
            end
            if (f == 17) begin
                exp_drop++;
                check("ovf_pulse", 64'(err_overflow), 64'd1);
                check("ovf_drop_count", 64'(drop_count), 64'(exp_drop));
                check("ovf_count", 64'(fifo_count), 64'd16);
            end
        end
        cmd  = 8'h12;
        data = 32'hCAFEF00D;
        send_frame(cmd, data, chk_of(cmd, data), 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        exp_q.push_back({cmd, data});
        check("full_pushpop_no_ovf", 64'(err_overflow), 64'd0);
        check("full_pushpop_count", 64'(fifo_count), 64'd16);
        check("full_pushpop_drop", 64'(drop_count), 64'(exp_drop));
        out_ready = 1'b1;
        repeat (16) tick();
        out_ready = 1'b0;
        check("drain_count", 64'(fifo_count), 64'd0);
        check("drain_model_left", 64'(exp_q.size()), 64'd0);

        // Reset mid-frame with packets queued.
        for (int f = 0; f < 3; f++) begin
            cmd  = 8'(8'h40 + f);
            data = $urandom;
            send_frame(cmd, data, chk_of(cmd, data), 0);
        end
        tick(); tick();
        check("pre_rst_count", 64'(fifo_count), 64'd3);
        send_byte(SYNC); send_byte(8'h10); send_byte(8'h44);
        errs_before = n_ovf + n_chk + n_to;
        rst = 1'b1;
        #2;
        check("midrst_count", 64'(fifo_count), 64'd0);
        check("midrst_valid", 64'(out_valid), 64'd0);
        check("midrst_drop", 64'(drop_count), 64'd0);
        rst = 1'b0;
        exp_q.delete();
        exp_drop = 0;
        tick(); tick(); tick();
        check("midrst_no_err", 64'(n_ovf + n_chk + n_to), 64'(errs_before));
        check("midrst_full", 64'(fifo_full), 64'd0);
        send_frame(8'h10, 32'h11223344, 8'h54, 0);
        tick();
        check("post_rst_valid", 64'(out_valid), 64'd1);
        check("post_rst_cmd", 64'(out_cmd), 64'h10);
        check("post_rst_data", 64'(out_data), 64'h11223344);
        exp_q.push_back({8'h10, 32'h11223344});

        // Randomized stream: junk, gaps, bad checksums, random consumer.
        chk_before = n_chk;
        ovf_before = n_ovf;
        to_before  = n_to;
        n_bad      = 0;
        rand_ready = 1'b1;
        for (int f = 0; f < 60; f++) begin
            repeat ($urandom_range(0, 2)) begin
                junk = 8'($urandom_range(0, 255));
                if (junk == SYNC) junk = 8'h00;
                send_byte(junk);
            end
            cmd  = 8'($urandom_range(0, 255));
            data = $urandom;
            chk  = chk_of(cmd, data);
            if ($urandom_range(0, 4) == 0) begin
                chk = chk ^ 8'($urandom_range(1, 255));
                n_bad++;
            end else begin
                exp_q.push_back({cmd, data});
            end
            send_frame(cmd, data, chk, 2);
        end
        repeat (4) tick();
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        repeat (40) tick();
        out_ready  = 1'b0;
        check("rand_model_drained", 64'(exp_q.size()), 64'd0);
        check("rand_fifo_count", 64'(fifo_count), 64'd0);
        check("rand_checksum_errs", 64'(n_chk - chk_before), 64'(n_bad));
        check("rand_no_overflow", 64'(n_ovf - ovf_before), 64'd0);
        check("rand_no_timeout", 64'(n_to - to_before), 64'd0);
        check("rand_drop_count", 64'(drop_count), 64'(exp_drop + n_bad));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
